// File: rtl/music_pkg.sv
// Constants, encodings and types shared by the note recorder and the music player.
package music_pkg;

    localparam int NOTE_W        = 5;
    localparam int DUR_W         = 4;
    localparam int NOTES_PER_OCT = 7;

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    typedef enum logic [1:0] {
        OCT_LOW  = 2'd0,
        OCT_MID  = 2'd1,
        OCT_HIGH = 2'd2
    } oct_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } score_event_t;

    // Octave code 3 is not a real octave and plays as mid.
    function automatic logic [NOTE_W-1:0] oct_base(input logic [1:0] oct);
        logic [NOTE_W-1:0] base;
        case (oct)
            OCT_LOW:  base = NOTE_W'(0);
            OCT_HIGH: base = NOTE_W'(2 * NOTES_PER_OCT);
            default:  base = NOTE_W'(NOTES_PER_OCT);
        endcase
        return base;
    endfunction

endpackage

// File: rtl/note_encoder.sv
// Priority encode of the note keys and octave into a note code.
module note_encoder
    import music_pkg::*;
(
    input  logic [6:0]        key,
    input  logic [1:0]        oct,
    output logic [NOTE_W-1:0] note
);

    // Scan downwards so the lowest pressed key is the last to assign.
    always_comb begin
        note = NOTE_REST;
        for (int i = 6; i >= 0; i--) begin
            if (key[i]) begin
                note = oct_base(oct) + NOTE_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/note_recorder.sv
// Records live key presses as quantised (note, duration) events in a score memory
// with a registered read port for the music player.
module note_recorder
    import music_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int UNIT_HZ   = 8,
    parameter int DEPTH     = 64,
    parameter int MAX_UNITS = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_en,
    input  logic [6:0]        key,
    input  logic [1:0]        oct,
    input  logic [5:0]        rd_addr,
    output logic [NOTE_W-1:0] rd_note,
    output logic [DUR_W-1:0]  rd_dur,
    output logic [6:0]        len,
    output logic              recording,
    output logic              full,
    output logic [23:0]       led
);

    localparam int UNIT_CYC = CLK_HZ / UNIT_HZ;
    localparam int PW       = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam int AW       = $clog2(DEPTH);

    logic [6:0]        key_s1, key_s2;
    logic [1:0]        oct_s1, oct_s2;
    logic [NOTE_W-1:0] enc_note, live_note;

    state_e            state, state_nx;
    logic [6:0]        len_nx;
    logic [NOTE_W-1:0] cur_note, cur_nx;
    logic [DUR_W-1:0]  units, units_nx;
    logic [PW-1:0]     presc, presc_nx;
    logic              armed, armed_nx;

    logic              wr_en;
    score_event_t      wr_ev;
    score_event_t      mem [DEPTH];

    note_encoder u_enc (
        .key  (key_s2),
        .oct  (oct_s2),
        .note (enc_note)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1    <= '0;
            key_s2    <= '0;
            oct_s1    <= '0;
            oct_s2    <= '0;
            live_note <= NOTE_REST;
        end else begin
            key_s1    <= key;
            key_s2    <= key_s1;
            oct_s1    <= oct;
            oct_s2    <= oct_s1;
            live_note <= enc_note;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            len      <= '0;
            cur_note <= NOTE_REST;
            units    <= '0;
            presc    <= '0;
            armed    <= 1'b0;
        end else begin
            state    <= state_nx;
            len      <= len_nx;
            cur_note <= cur_nx;
            units    <= units_nx;
            presc    <= presc_nx;
            armed    <= armed_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        len_nx     = len;
        cur_nx     = cur_note;
        units_nx   = units;
        presc_nx   = presc;
        armed_nx   = armed;
        wr_en      = 1'b0;
        wr_ev.note = cur_note;
        wr_ev.dur  = units;
        case (state)
            ST_IDLE: begin
                if (rec_en) begin
                    state_nx = ST_RUN;
                    len_nx   = '0;
                    cur_nx   = NOTE_REST;
                    units_nx = '0;
                    presc_nx = '0;
                    armed_nx = 1'b0;
                end
            end
            ST_RUN: begin
                if (!rec_en) begin
                    state_nx = ST_IDLE;
                    wr_en    = armed && (units != '0);
                end else if (!armed) begin
                    if (live_note != NOTE_REST) begin
                        armed_nx = 1'b1;
                        cur_nx   = live_note;
                        units_nx = '0;
                        presc_nx = '0;
                    end
                end else if (live_note != cur_note) begin
                    // Zero-unit events are key glitches and are dropped.
                    wr_en    = (units != '0);
                    cur_nx   = live_note;
                    units_nx = '0;
                    presc_nx = '0;
                end else if (presc == PW'(UNIT_CYC - 1)) begin
                    presc_nx = '0;
                    if (units == DUR_W'(MAX_UNITS - 1)) begin
                        wr_en     = 1'b1;
                        wr_ev.dur = DUR_W'(MAX_UNITS);
                        units_nx  = '0;
                    end else begin
                        units_nx = units + DUR_W'(1);
                    end
                end else begin
                    presc_nx = presc + PW'(1);
                end
                if (wr_en) begin
                    len_nx = len + 7'd1;
                    if (rec_en && len_nx == 7'(DEPTH)) begin
                        state_nx = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!rec_en) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[len[AW-1:0]] <= wr_ev;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_note <= NOTE_REST;
            rd_dur  <= '0;
        end else if ({1'b0, rd_addr} < len) begin
            rd_note <= mem[rd_addr].note;
            rd_dur  <= mem[rd_addr].dur;
        end else begin
            rd_note <= NOTE_REST;
            rd_dur  <= '0;
        end
    end

    assign recording = (state == ST_RUN);
    assign full      = (len == 7'(DEPTH));

    always_comb begin
        led = '0;
        if (recording && live_note != NOTE_REST) begin
            led[20:0] = 21'(1) << (live_note - NOTE_W'(1));
        end
        led[21] = recording;
        led[22] = full;
        led[23] = (state == ST_IDLE) && (len != '0);
    end

endmodule

// File: doc/note_recorder.md
# note_recorder

Captures notes played live on the board's note keys and stores them as a score of (note code, duration) events that the music player replays through the buzzer. It is the write side of the score format the player reads: key presses become quantised events in an internal score memory, and a registered read port lets the player fetch them by address. It sits beside the player under the top level and shares its clock, reset and LED bank.

## Interface
- CLK_HZ, 100_000_000: clock frequency.
- UNIT_HZ, 8: duration quanta per second; one unit lasts CLK_HZ/UNIT_HZ cycles, called UNIT_CYC.
- DEPTH, 64: score capacity in events.
- MAX_UNITS, 15: longest single event, in units.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- rec_en, input, 1: level. 1 requests recording.
- key, input, 7: note keys do..si, asynchronous. If several are high, the lowest index wins.
- oct, input, 2: octave. 0 = low, 1 = mid, 2 = high, 3 is treated as mid.
- rd_addr, input, 6: score read address.
- rd_note, output, 5: note code at rd_addr.
- rd_dur, output, 4: duration at rd_addr, in units.
- len, output, 7: number of events stored.
- recording, output, 1: state is RUN.
- full, output, 1: len == DEPTH.
- led, output, 24: status display.

## Operation
- Note code: 0 = rest; a pressed key gives oct*7 + index + 1, range 1..21.
- Input path: key and oct pass through a 2-flop synchroniser, then the encoded note is registered as live_note.
- States:
  - IDLE: enters RUN when rec_en=1. On that entry, len clears to 0, cur_note=0, units=0, presc=0 and armed=0.
  - RUN: records events (rules below).
  - HOLD: entered when len reaches DEPTH. No writes occur. Leaves to IDLE when rec_en=0.
- RUN, before the first note:
  - While armed=0, live_note=0 is ignored, so leading silence is not recorded.
  - The first nonzero live_note sets armed=1 and cur_note, and starts counting.
- RUN, counting:
  - presc counts 0..UNIT_CYC-1.
  - When presc wraps, units increments.
- RUN, note change (live_note != cur_note, armed=1):
  - If units ≥ 1, write (cur_note, units) at address len and increment len.
  - If units = 0, drop the event (glitch filter).
  - Then cur_note=live_note, units=0, presc=0.
  - A presc wrap in the same cycle as a change is discarded.
- RUN, split: when units reaches MAX_UNITS, write (cur_note, 15), set units=0 and continue the same note with no gap.
- RUN, stop: rec_en=0 commits the pending event if armed and units ≥ 1 (a trailing rest is kept), then the state goes to IDLE.
- Filling up: the write that makes len=DEPTH moves the state to HOLD and sets full.
- Width rule: len is 7 bits so it can hold DEPTH=64.
- Read port: rd_note/rd_dur are registered. If rd_addr ≥ len, both return 0.
- LEDs:
  - led[20:0]: one-hot bit (live_note − 1) while in RUN with live_note ≠ 0.
  - led[21] = recording.
  - led[22] = full.
  - led[23] = IDLE with len > 0.
- Reset: state=IDLE, len=0, all outputs 0. Memory contents are left as they are but are unreadable because len=0. A reset during RUN discards the pending event.

## Timing
- From a key change to live_note: 3 cycles (2 sync + 1 encode).
- A memory write and the len increment happen on the same edge, 1 cycle after live_note changes.
- recording rises 1 cycle after rec_en is seen high in IDLE.
- Reading: data appears 1 cycle after rd_addr. A write to the address being read shows on the next read, not the same cycle.
- Reading and writing may happen in the same cycle with no stall.

## Structure
- Shared package music_pkg holds the note code width (5), duration width (4), NOTE_REST=0, the octave encoding, and the state enum. The music player uses the same constants.
- One sub-module, note_encoder: the combinational priority encode of key+oct to a note code. The synchroniser and live_note register live in the parent.
- Score memory is an inferred DEPTH×9 register array with a synchronous read.

## Test plan
All scenarios use CLK_HZ=16, UNIT_HZ=1, so UNIT_CYC=16.
- Reset then record a single note: rec_en=1, oct=1, key=0000001 held 50 cycles then released; rec_en drops 40 cycles later. Required: entry0=(8,3), entry1=(0,2), len=2, led[23]=1.
- Glitch filter: key[2] pulsed for 10 cycles inside a held note. Required: no entry with note 10; the surrounding note is split into two events.
- Split: oct=2, key[6] held 300 cycles. Required: entry0=(21,15), entry1=(21,3), no gap between them.
- Capacity: 64 alternating 1-unit events. Required: full=1, len=64, the 65th change writes nothing, and HOLD exits once rec_en=0.
- Reset during RUN with len=5: pulse rst. Required: next cycle len=0, recording=0, led=0, rd_note=0 for every address.
- Multiple keys key=0100100 with oct=3: required note code 10 (mid octave, index 2).
